// File: rtl/word2bits_pulse.sv
// word2bits_pulse: fans a W-bit control word out to W registered lines, each a latched level or stretched pulse.
// Latency: dout and busy update on the clock edge after the din_valid cycle; pulses last max(plen,1) cycles.
// Backpressure: none; a write is accepted every cycle din_valid is high. Optional per-bit write mask under WORD2BITS_MASK_EN.
module word2bits_pulse #(
  parameter int W  = 8,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [W-1:0]  din,
  input  logic          din_valid,
  input  logic [W-1:0]  mode,
  input  logic [PW-1:0] plen,
`ifdef WORD2BITS_MASK_EN
  input  logic [W-1:0]  din_mask,
`endif
  output logic [W-1:0]  dout,
  output logic          busy
);

  // Registered state. A bit's mode needs no separate storage: a nonzero
  // counter means "pulse in progress", zero means "holding a level".
  logic [W-1:0]  dout_q, dout_d;
  logic [PW-1:0] cnt_q [W];
  logic [PW-1:0] cnt_d [W];
  logic          busy_q, busy_d;

  // Per-bit write decode
  logic [W-1:0]  wr_mask;
  logic [W-1:0]  wr_level;
  logic [W-1:0]  wr_fire;
  logic [PW-1:0] plen_eff;

  // Select which bits a write touches; without the mask every bit is enabled
  always_comb begin
`ifdef WORD2BITS_MASK_EN
    wr_mask = din_mask;
`else
    wr_mask = '1;
`endif
  end

  // Classify each bit of a write: level load, pulse fire, or untouched.
  // A zero pulse length still produces a single-cycle pulse.
  always_comb begin
    wr_level = '0;
    wr_fire  = '0;
    plen_eff = (plen == '0) ? PW'(1) : plen;
    if (din_valid) begin
      wr_level = wr_mask & ~mode;
      wr_fire  = wr_mask & mode & din;
    end
  end

  // Next state per bit: writes take priority, otherwise the pulse counter runs down
  always_comb begin
    dout_d = dout_q;
    for (int i = 0; i < W; i++) begin
      cnt_d[i] = cnt_q[i];
      if (wr_level[i]) begin
        // Level load also cancels any pulse in flight
        dout_d[i] = din[i];
        cnt_d[i]  = '0;
      end else if (wr_fire[i]) begin
        // Fire or retrigger: reload the counter, no gap in the output
        dout_d[i] = 1'b1;
        cnt_d[i]  = plen_eff;
      end else if (cnt_q[i] > PW'(1)) begin
        cnt_d[i]  = cnt_q[i] - PW'(1);
      end else if (cnt_q[i] == PW'(1)) begin
        // Last pulse cycle: drop the line together with the counter
        dout_d[i] = 1'b0;
        cnt_d[i]  = '0;
      end
    end
  end

  // busy is derived from the next counter values so it registers alongside dout
  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (cnt_d[i] != '0) begin
        busy_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset; reset aborts pulses at once
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout_q <= '0;
      busy_q <= 1'b0;
      for (int i = 0; i < W; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      dout_q <= dout_d;
      busy_q <= busy_d;
      for (int i = 0; i < W; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_word2bits_pulse.sv
// tb_word2bits_pulse: directed vector table plus randomized run against a time-stamp reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none; stimulus is applied every cycle.
module tb_word2bits_pulse;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] din;
  logic       din_valid;
  logic [7:0] mode;
  logic [3:0] plen;
`ifdef WORD2BITS_MASK_EN
  logic [7:0] din_mask;
`endif
  logic [7:0] dout;
  logic       busy;

  word2bits_pulse #(.W(8), .PW(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .din       (din),
    .din_valid (din_valid),
    .mode      (mode),
    .plen      (plen),
`ifdef WORD2BITS_MASK_EN
    .din_mask  (din_mask),
`endif
    .dout      (dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: each bit has a resting level and the index of the last
  // edge after which a pulse still holds it high (-1 = no pulse).
  int   edge_n = 0;
  int   end_c [8];
  logic lvl   [8];

  typedef struct {
    logic       rstn;
    logic       dv;
    logic [7:0] din;
    logic [7:0] mode;
    logic [3:0] plen;
    logic [7:0] mask;
    logic [7:0] exp_dout;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic dv, input logic [7:0] d,
                              input logic [7:0] m, input logic [3:0] p, input logic [7:0] mk,
                              input logic [7:0] ed, input logic eb);
    vec_t v;
    v.rstn = r; v.dv = dv; v.din = d; v.mode = m; v.plen = p; v.mask = mk;
    v.exp_dout = ed; v.exp_busy = eb;
    vecs.push_back(v);
  endfunction

  function automatic void idle(input logic [7:0] ed, input logic eb);
    add(1'b1, 1'b0, 8'h00, 8'h00, 4'd0, 8'hFF, ed, eb);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Apply one cycle of stimulus, clock it, advance the model, sample after the edge
  task automatic step(input logic r, input logic dv, input logic [7:0] d, input logic [7:0] m,
                      input logic [3:0] p, input logic [7:0] mk);
    int len;
    rstn = r; din_valid = dv; din = d; mode = m; plen = p;
`ifdef WORD2BITS_MASK_EN
    din_mask = mk;
`endif
    @(posedge clk);
    edge_n++;
    len = (p == 4'd0) ? 1 : int'(p);
    for (int i = 0; i < 8; i++) begin
      if (!r) begin
        lvl[i] = 1'b0; end_c[i] = -1;
      end else if (dv && (mk[i]
`ifndef WORD2BITS_MASK_EN
                          || 1'b1
`endif
                         )) begin
        if (!m[i]) begin
          lvl[i] = d[i]; end_c[i] = -1;
        end else if (d[i]) begin
          lvl[i] = 1'b0; end_c[i] = edge_n + len - 1;
        end
      end
    end
    #1;
  endtask

  function automatic logic [7:0] model_dout();
    logic [7:0] o;
    for (int i = 0; i < 8; i++) o[i] = (end_c[i] >= edge_n) ? 1'b1 : lvl[i];
    return o;
  endfunction

  function automatic logic model_busy();
    logic b = 1'b0;
    for (int i = 0; i < 8; i++) if (end_c[i] >= edge_n) b = 1'b1;
    return b;
  endfunction

  initial begin
    rstn = 1'b0; din_valid = 1'b0; din = '0; mode = '0; plen = '0;
`ifdef WORD2BITS_MASK_EN
    din_mask = '1;
`endif
    for (int i = 0; i < 8; i++) begin lvl[i] = 1'b0; end_c[i] = -1; end

    // Reset with garbage on the inputs
    for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 8'hFF, 8'hAA, 4'd7, 8'hFF, 8'h00, 1'b0);
    // Level write, hold, clear
    add(1'b1, 1'b1, 8'hA5, 8'h00, 4'd0, 8'hFF, 8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) idle(8'hA5, 1'b0);
    add(1'b1, 1'b1, 8'h00, 8'h00, 4'd0, 8'hFF, 8'h00, 1'b0);
    // Pulse plen=3, then plen=0 (single cycle)
    add(1'b1, 1'b1, 8'h01, 8'h01, 4'd3, 8'hFF, 8'h01, 1'b1);
    idle(8'h01, 1'b1); idle(8'h01, 1'b1); idle(8'h00, 1'b0);
    add(1'b1, 1'b1, 8'h01, 8'h01, 4'd0, 8'hFF, 8'h01, 1'b1);
    idle(8'h00, 1'b0);
    // Retrigger plen=5 at t, plen=2 at t+3: high t+1..t+5
    add(1'b1, 1'b1, 8'h01, 8'h01, 4'd5, 8'hFF, 8'h01, 1'b1);
    idle(8'h01, 1'b1); idle(8'h01, 1'b1);
    add(1'b1, 1'b1, 8'h01, 8'h01, 4'd2, 8'hFF, 8'h01, 1'b1);
    idle(8'h01, 1'b1); idle(8'h00, 1'b0);
    // Pulse cancelled by level write of 0
    add(1'b1, 1'b1, 8'h01, 8'h01, 4'd5, 8'hFF, 8'h01, 1'b1);
    idle(8'h01, 1'b1);
    add(1'b1, 1'b1, 8'h00, 8'h00, 4'd0, 8'hFF, 8'h00, 1'b0);
    // Pulse-mode write with din=0 has no effect
    add(1'b1, 1'b1, 8'h02, 8'h02, 4'd3, 8'hFF, 8'h02, 1'b1);
    add(1'b1, 1'b1, 8'h00, 8'h02, 4'd9, 8'hFF, 8'h02, 1'b1);
    idle(8'h02, 1'b1); idle(8'h00, 1'b0);
    add(1'b1, 1'b1, 8'h00, 8'hFF, 4'd4, 8'hFF, 8'h00, 1'b0);
    // Mixed: low nibble level, high nibble 15-cycle pulse
    add(1'b1, 1'b1, 8'hFF, 8'hF0, 4'd15, 8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 14; i++) idle(8'hFF, 1'b1);
    idle(8'h0F, 1'b0);
    // Reset mid-pulse
    add(1'b1, 1'b1, 8'hFF, 8'hF0, 4'd15, 8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) idle(8'hFF, 1'b1);
    add(1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 8'hFF, 8'h00, 1'b0);
`ifdef WORD2BITS_MASK_EN
    // Masked writes: level bits and a running pulse on a masked-off bit
    add(1'b1, 1'b1, 8'hFF, 8'h00, 4'd0, 8'hFF, 8'hFF, 1'b0);
    add(1'b1, 1'b1, 8'h00, 8'h00, 4'd0, 8'h0F, 8'hF0, 1'b0);
    add(1'b1, 1'b1, 8'h01, 8'h01, 4'd4, 8'h01, 8'hF1, 1'b1);
    add(1'b1, 1'b1, 8'h00, 8'h00, 4'd0, 8'hFE, 8'h01, 1'b1);
    idle(8'h01, 1'b1); idle(8'h01, 1'b1); idle(8'h00, 1'b0);
`endif

    foreach (vecs[k]) begin
      step(vecs[k].rstn, vecs[k].dv, vecs[k].din, vecs[k].mode, vecs[k].plen, vecs[k].mask);
      chk($sformatf("vec%0d_dout", k), {24'd0, dout}, {24'd0, vecs[k].exp_dout});
      chk($sformatf("vec%0d_busy", k), {31'd0, busy}, {31'd0, vecs[k].exp_busy});
    end

    // Randomized run against the reference model
    step(1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 8'hFF);
    for (int c = 0; c < 3000; c++) begin
      logic       r, dv;
      logic [7:0] d, m, mk;
      logic [3:0] p;
      r  = ($urandom_range(63) != 0);
      dv = ($urandom_range(3) == 0);
      d  = 8'($urandom);
      m  = 8'($urandom);
      p  = 4'($urandom);
      mk = 8'($urandom);
      step(r, dv, d, m, p, mk);
      chk($sformatf("rnd%0d_dout", c), {24'd0, dout}, {24'd0, model_dout()});
      chk($sformatf("rnd%0d_busy", c), {31'd0, busy}, {31'd0, model_busy()});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
